framebuffer_port_arbiter: RTL and testbench



---
 rtl/framebuffer_port_arbiter.sv | 126 ++++++++++++
 tb/tb_framebuffer_port_arbiter.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/framebuffer_port_arbiter.sv
// framebuffer_port_arbiter: shares one synchronous-read framebuffer port between
// display scan-out (highest priority), a clear-screen sweep and a lab-side pixel writer.
module framebuffer_port_arbiter #(
    parameter int screen_width  = 640,
    parameter int screen_height = 480,
    parameter int w_x           = $clog2(screen_width),
    parameter int w_y           = $clog2(screen_height),
    parameter int w_pixel       = 24,
    parameter int w_addr        = $clog2(screen_width*screen_height)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pixel_en,
    input  logic               display_on,
    input  logic [w_x-1:0]     x,
    input  logic [w_y-1:0]     y,
    output logic [w_pixel-1:0] pix_out,
    output logic               pix_valid,
    input  logic               wr_valid,
    output logic               wr_ready,
    input  logic [w_x-1:0]     wr_x,
    input  logic [w_y-1:0]     wr_y,
    input  logic [w_pixel-1:0] wr_data,
    input  logic               clear_req,
    input  logic [w_pixel-1:0] clear_color,
    output logic               clear_busy,
    output logic               clear_done,
    output logic [15:0]        drop_count,
    output logic [w_addr-1:0]  mem_addr,
    output logic               mem_we,
    output logic [w_pixel-1:0] mem_wdata,
    input  logic [w_pixel-1:0] mem_rdata
);
    typedef enum logic {IDLE, CLEAR} state_t;
    localparam logic [w_addr-1:0] last_addr = w_addr'(screen_width*screen_height-1);
    localparam logic [w_addr-1:0] width_a = w_addr'(screen_width);
    localparam logic [w_x:0] x_lim = (w_x+1)'(screen_width);
    localparam logic [w_y:0] y_lim = (w_y+1)'(screen_height);
    state_t state_q, state_d;
    logic [w_addr-1:0] cnt_q, cnt_d;
    logic [w_pixel-1:0] color_q, color_d;
    logic [w_pixel-1:0] pix_q, pix_d;
    logic [15:0] drop_q, drop_d;
    logic done_q, done_d;
    logic pv_q, pv_d;
    logic rd1_q, rd1_d;
    logic on1_q, on1_d;
    logic rd, clr_wr, wr_fire, in_range;
    assign rd       = pixel_en && display_on;
    assign clr_wr   = state_q == CLEAR && !rd;
    assign wr_fire  = state_q == IDLE && !rd && wr_valid;
    assign in_range = {1'b0, wr_x} < x_lim && {1'b0, wr_y} < y_lim;
    always_comb begin
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        if (!rst) begin
            if (rd) begin
                mem_addr = w_addr'(y) * width_a + w_addr'(x);
            end else if (clr_wr) begin
                mem_addr  = cnt_q;
                mem_wdata = color_q;
                mem_we    = 1'b1;
            end else if (wr_fire && in_range) begin
                mem_addr  = w_addr'(wr_y) * width_a + w_addr'(wr_x);
                mem_wdata = wr_data;
                mem_we    = 1'b1;
            end
        end
    end
    assign wr_ready = !rst && state_q == IDLE && !rd;
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        color_d = color_q;
        done_d  = 1'b0;
        drop_d  = drop_q;
        if (state_q == IDLE && clear_req) begin
            state_d = CLEAR;
            cnt_d   = '0;
            color_d = clear_color;
        end
        // the counter only advances on cycles that actually wrote, so display reads never leave gaps
        if (clr_wr) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == last_addr) begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
        end
        if (wr_fire && !in_range && drop_q != 16'hFFFF)
            drop_d = drop_q + 16'd1;
        rd1_d = pixel_en;
        on1_d = display_on;
        pv_d  = rd1_q;
        pix_d = rd1_q ? (on1_q ? mem_rdata : '0) : pix_q;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            color_q <= '0;
            done_q  <= 1'b0;
            drop_q  <= '0;
            pix_q   <= '0;
            pv_q    <= 1'b0;
            rd1_q   <= 1'b0;
            on1_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            color_q <= color_d;
            done_q  <= done_d;
            drop_q  <= drop_d;
            pix_q   <= pix_d;
            pv_q    <= pv_d;
            rd1_q   <= rd1_d;
            on1_q   <= on1_d;
        end
    end
    assign pix_out    = pix_q;
    assign pix_valid  = pv_q;
    assign clear_busy = state_q == CLEAR;
    assign clear_done = done_q;
    assign drop_count = drop_q;
endmodule

// File: tb/tb_framebuffer_port_arbiter.sv
// tb_framebuffer_port_arbiter: scoreboard bench on a 40x30 screen so a full clear sweep stays short.
module tb_framebuffer_port_arbiter;
    localparam int W = 40;
    localparam int H = 30;
    localparam int N = W * H;
    typedef struct {logic [23:0] d; int c;} pix_t;
    typedef struct {logic [10:0] a; logic [23:0] d;} wr_t;
    logic clk = 1'b0;
    logic rst, pixel_en, display_on, wr_valid, wr_ready, clear_req, clear_busy, clear_done;
    logic pix_valid, mem_we;
    logic [5:0] x, wr_x;
    logic [4:0] y, wr_y;
    logic [23:0] pix_out, wr_data, clear_color, mem_wdata, mem_rdata;
    logic [15:0] drop_count;
    logic [10:0] mem_addr;
    logic [23:0] ram [0:2047];
    pix_t exp_pix[$];
    wr_t exp_wr[$];
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int wcount = 0;
    int done_cnt = 0;
    logic prev_last = 1'b0;

    framebuffer_port_arbiter #(.screen_width(W), .screen_height(H)) dut (
        .clk(clk), .rst(rst), .pixel_en(pixel_en), .display_on(display_on), .x(x), .y(y),
        .pix_out(pix_out), .pix_valid(pix_valid), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_x(wr_x), .wr_y(wr_y), .wr_data(wr_data), .clear_req(clear_req),
        .clear_color(clear_color), .clear_busy(clear_busy), .clear_done(clear_done),
        .drop_count(drop_count), .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #4 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    // monitor: pops expectations whenever the DUT presents a pixel or a RAM write
    always @(negedge clk) begin
        pix_t p;
        wr_t w;
        if (pix_valid) begin
            checks++;
            if (exp_pix.size() == 0) begin
                errors++;
                $display("FAIL pix_unexpected got %h", pix_out);
            end else begin
                p = exp_pix.pop_front();
                if (pix_out !== p.d || cyc != p.c) begin
                    errors++;
                    $display("FAIL pix got %h at cycle %0d expected %h at cycle %0d", pix_out, cyc, p.d, p.c);
                end
            end
        end
        if (mem_we) begin
            checks++;
            if (clear_busy) wcount++;
            if (exp_wr.size() == 0) begin
                errors++;
                $display("FAIL wr_unexpected got addr %0d data %h", mem_addr, mem_wdata);
            end else begin
                w = exp_wr.pop_front();
                if (mem_addr !== w.a || mem_wdata !== w.d) begin
                    errors++;
                    $display("FAIL wr got addr %0d data %h expected addr %0d data %h", mem_addr, mem_wdata, w.a, w.d);
                end
            end
        end
        if (clear_done || prev_last) begin
            checks++;
            if (clear_done !== prev_last) begin
                errors++;
                $display("FAIL clear_done got %b expected %b", clear_done, prev_last);
            end
        end
        prev_last = mem_we && clear_busy && mem_addr == 11'(N - 1);
        if (clear_done) done_cnt++;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic pix(input logic on, input int px, input int py, input logic [23:0] e);
        pixel_en = 1'b1;
        display_on = on;
        x = 6'(px);
        y = 5'(py);
        #1;
        exp_pix.push_back('{e, cyc + 2});
        chk("pix_mem_we", 32'(mem_we), 0);
        if (on) chk("pix_mem_addr", 32'(mem_addr), 32'(py * W + px));
        tick;
        pixel_en = 1'b0;
    endtask

    task automatic wr(input int wx, input int wy, input logic [23:0] d);
        wr_valid = 1'b1;
        wr_x = 6'(wx);
        wr_y = 5'(wy);
        wr_data = d;
        #1;
        chk("wr_ready", 32'(wr_ready), 1);
        if (wx < W && wy < H) exp_wr.push_back('{11'(wy * W + wx), d});
        else chk("oor_mem_we", 32'(mem_we), 0);
        tick;
        wr_valid = 1'b0;
    endtask

    task automatic push_clear(input logic [23:0] c);
        for (int i = 0; i < N; i++) exp_wr.push_back('{11'(i), c});
    endtask

    task automatic sweep(input string name, input int budget, output int bad);
        int n;
        bad = 0;
        for (n = 0; n < budget && clear_busy; n++) begin
            pixel_en = (n % 5 == 0);
            display_on = 1'b1;
            x = 6'((n / 5) % W);
            y = 5'((n / 200) % H);
            #1;
            if (pixel_en) exp_pix.push_back('{ram[int'(y) * W + int'(x)], cyc + 2});
            if (wr_ready) bad++;
            tick;
        end
        pixel_en = 1'b0;
        chk({name, "_finished"}, 32'(n < budget), 1);
    endtask

    initial begin
        int bad, dn, n;
        rst = 1'b1; pixel_en = 1'b1; display_on = 1'b1; x = 6'd3; y = 5'd2;
        wr_valid = 1'b1; wr_x = 6'd1; wr_y = 5'd1; wr_data = 24'h1;
        clear_req = 1'b0; clear_color = 24'h0;
        tick;
        tick;
        chk("rst_pix_out", 32'(pix_out), 0);
        chk("rst_pix_valid", 32'(pix_valid), 0);
        chk("rst_clear_busy", 32'(clear_busy), 0);
        chk("rst_clear_done", 32'(clear_done), 0);
        chk("rst_drop_count", 32'(drop_count), 0);
        chk("rst_mem_we", 32'(mem_we), 0);
        chk("rst_mem_addr", 32'(mem_addr), 0);
        chk("rst_wr_ready", 32'(wr_ready), 0);
        rst = 1'b0; pixel_en = 1'b0; wr_valid = 1'b0;
        tick;
        wr(3, 2, 24'hA5A5A5);
        tick;
        for (int k = 0; k < 3; k++) begin
            pix(1'b1, 3, 2, 24'hA5A5A5);
            repeat (4) tick;
        end
        pix(1'b0, 3, 2, 24'h0);
        repeat (4) tick;
        // writer collides with a display read and must land once, on the next free cycle
        wr_valid = 1'b1; wr_x = 6'd10; wr_y = 5'd1; wr_data = 24'h00FF00;
        pixel_en = 1'b1; display_on = 1'b1; x = 6'd3; y = 5'd2;
        #1;
        exp_pix.push_back('{24'hA5A5A5, cyc + 2});
        chk("collide_wr_ready", 32'(wr_ready), 0);
        chk("collide_mem_addr", 32'(mem_addr), 83);
        exp_wr.push_back('{11'd50, 24'h00FF00});
        tick;
        pixel_en = 1'b0;
        #1;
        chk("pending_wr_ready", 32'(wr_ready), 1);
        tick;
        wr_valid = 1'b0;
        repeat (3) tick;
        pix(1'b1, 10, 1, 24'h00FF00);
        repeat (4) tick;
        wr(W - 1, H - 1, 24'h123456);
        pix(1'b1, W - 1, H - 1, 24'h123456);
        repeat (4) tick;
        wr(W, 0, 24'h777777);
        wr(0, H, 24'h888888);
        chk("drop_count", 32'(drop_count), 2);
        // clear request in the same cycle as a writer handshake: the write goes first
        wr_valid = 1'b1; wr_x = 6'd5; wr_y = 5'd0; wr_data = 24'hABCDEF;
        clear_req = 1'b1; clear_color = 24'h102030;
        #1;
        chk("clear_wr_ready", 32'(wr_ready), 1);
        exp_wr.push_back('{11'd5, 24'hABCDEF});
        push_clear(24'h102030);
        tick;
        wr_valid = 1'b0; clear_req = 1'b0; clear_color = 24'h0;
        chk("clear_busy_on", 32'(clear_busy), 1);
        sweep("sweep1", 5000, bad);
        chk("sweep_wr_ready_low", 32'(bad), 0);
        tick;
        chk("sweep_done_count", 32'(done_cnt), 1);
        chk("sweep_wr_left", 32'(exp_wr.size()), 0);
        pix(1'b1, 20, 15, 24'h102030);
        repeat (4) tick;
        // abandon a sweep with reset after its 1000th write, then restart it
        wcount = 0;
        clear_req = 1'b1; clear_color = 24'h0F0F0F;
        push_clear(24'h0F0F0F);
        tick;
        clear_req = 1'b0;
        for (n = 0; n < 5000 && wcount < 1000; n++) tick;
        chk("abort_reached_1000", 32'(wcount), 1000);
        rst = 1'b1;
        exp_wr.delete();
        dn = done_cnt;
        #1;
        chk("abort_mem_we", 32'(mem_we), 0);
        tick;
        chk("abort_busy", 32'(clear_busy), 0);
        rst = 1'b0;
        repeat (2) tick;
        chk("abort_no_done", 32'(done_cnt), 32'(dn));
        chk("abort_busy_after", 32'(clear_busy), 0);
        clear_req = 1'b1;
        push_clear(24'h0F0F0F);
        tick;
        clear_req = 1'b0;
        sweep("sweep2", 5000, bad);
        chk("sweep2_wr_ready_low", 32'(bad), 0);
        tick;
        chk("sweep2_done_count", 32'(done_cnt), 32'(dn + 1));
        repeat (5) tick;
        chk("pix_queue_empty", 32'(exp_pix.size()), 0);
        chk("wr_queue_empty", 32'(exp_wr.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
